sram_fb_arbiter: RTL and testbench

Parametrised single-clock SRAM framebuffer controller. It is the successor to the current pixel-SRAM path and sits between the CPU bus, the GPU pixel fetch and the external asynchronous SRAM.
- Adds an integrated write FIFO of configurable depth with fill level and overflow reporting.
- Adds a coherent CPU read-back port and a configurable SRAM base offset.
- GPU reads take priority. CPU traffic drains only while the GPU marks the SRAM free (blanking or line-buffer use).

---
 rtl/sram_fb_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_sram_fb_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_fb_arbiter.sv
// ---------------------------------------------------------------------------
// sram_fb_arbiter
//   Single-clock framebuffer controller sitting between the CPU bus, the GPU
//   pixel fetch and an external asynchronous SRAM. CPU writes are queued in
//   an internal FIFO; GPU pixel reads always win arbitration, CPU reads and
//   FIFO drains only run while the GPU leaves the SRAM free (gpu_active=0).
//   A pending CPU read waits for the FIFO to empty, so read-after-write is
//   coherent. Every output is driven from a register.
//
// Ports
//   clk100, reset          clock and synchronous active-high reset
//   cpu_we/addr/data       write push into the FIFO (dropped when full)
//   cpu_rd_req/addr        read request, accepted only while not busy
//   cpu_rd_data/valid/busy read result, 1-cycle valid pulse, busy flag
//   fifo_level/full/overflow  FIFO occupancy, full flag, sticky drop flag
//   gpu_active             GPU owns the SRAM; blocks new CPU operations
//   gpu_rd_req/addr        pixel read request (one outstanding, latest wins)
//   gpu_data/valid         pixel result, 1-cycle valid pulse
//   sram_*                 SRAM address, data pads and active-low controls
// ---------------------------------------------------------------------------
module sram_fb_arbiter #(
    parameter int unsigned ADDR_WIDTH      = 17,
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned SRAM_ADDR_WIDTH = 19,
    parameter int unsigned FIFO_DEPTH      = 512,
    parameter int unsigned BASE_ADDR       = 0
) (
    input  logic                               clk100,
    input  logic                               reset,
    input  logic                               cpu_we,
    input  logic [ADDR_WIDTH-1:0]              cpu_addr,
    input  logic [DATA_WIDTH-1:0]              cpu_data,
    input  logic                               cpu_rd_req,
    input  logic [ADDR_WIDTH-1:0]              cpu_rd_addr,
    output logic [DATA_WIDTH-1:0]              cpu_rd_data,
    output logic                               cpu_rd_valid,
    output logic                               cpu_rd_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic                               fifo_full,
    output logic                               fifo_overflow,
    input  logic                               gpu_active,
    input  logic                               gpu_rd_req,
    input  logic [ADDR_WIDTH-1:0]              gpu_addr,
    output logic [DATA_WIDTH-1:0]              gpu_data,
    output logic                               gpu_data_valid,
    output logic [SRAM_ADDR_WIDTH-1:0]         sram_addr,
    output logic [DATA_WIDTH-1:0]              sram_dq_out,
    input  logic [DATA_WIDTH-1:0]              sram_dq_in,
    output logic                               sram_dq_oe,
    output logic                               sram_cs_n,
    output logic                               sram_oe_n,
    output logic                               sram_we_n
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ENT_W = ADDR_WIDTH + DATA_WIDTH;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_GRD1 = 3'd1;
    localparam logic [2:0] S_GRD2 = 3'd2;
    localparam logic [2:0] S_CRD1 = 3'd3;
    localparam logic [2:0] S_CRD2 = 3'd4;
    localparam logic [2:0] S_WR1  = 3'd5;
    localparam logic [2:0] S_WR2  = 3'd6;
    localparam logic [2:0] S_WR3  = 3'd7;

    // Framebuffer address to SRAM address; wraps modulo 2^SRAM_ADDR_WIDTH.
    function automatic logic [SRAM_ADDR_WIDTH-1:0] map_addr(input logic [ADDR_WIDTH-1:0] a);
        return SRAM_ADDR_WIDTH'(a) + SRAM_ADDR_WIDTH'(BASE_ADDR);
    endfunction

    logic [2:0]                 state_q, state_d;
    logic [ENT_W-1:0]           fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]           level_q, level_d;
    logic                       full_q, full_d, ovf_q, ovf_d;
    logic                       gpu_pend_q, gpu_pend_d;
    logic [ADDR_WIDTH-1:0]      gpu_addr_q, gpu_addr_d;
    logic                       cpu_pend_q, cpu_pend_d;
    logic [ADDR_WIDTH-1:0]      cpu_addr_q, cpu_addr_d;
    logic                       busy_q, busy_d;
    logic [DATA_WIDTH-1:0]      gdata_q, gdata_d, cdata_q, cdata_d;
    logic                       gvalid_q, gvalid_d, cvalid_q, cvalid_d;
    logic [SRAM_ADDR_WIDTH-1:0] saddr_q, saddr_d;
    logic [DATA_WIDTH-1:0]      dq_out_q, dq_out_d;
    logic                       dq_oe_q, dq_oe_d, cs_n_q, cs_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;

    logic                       push, pop, accept, fifo_empty, rd_state;
    logic [ENT_W-1:0]           head;

    assign fifo_empty = (level_q == '0);
    assign push       = cpu_we && !full_q;
    assign accept     = cpu_rd_req && !busy_q;
    assign head       = fifo_mem[rd_ptr_q];

    // Arbitration and sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (gpu_pend_q)                                 state_d = S_GRD1;
                else if (cpu_pend_q && !gpu_active && fifo_empty) state_d = S_CRD1;
                else if (!fifo_empty && !gpu_active)            state_d = S_WR1;
            end
            S_GRD1: state_d = S_GRD2;
            S_GRD2: state_d = S_IDLE;
            S_CRD1: state_d = S_CRD2;
            S_WR1:  state_d = S_WR2;
            S_WR2:  state_d = S_WR3;
            // A GPU request that arrived mid-operation is chained straight in.
            S_CRD2, S_WR3: state_d = gpu_pend_q ? S_GRD1 : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO bookkeeping; the pop coincides with the edge that enters WR1.
    always_comb begin
        pop      = (state_d == S_WR1);
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop)      level_d = level_q + LVL_W'(1);
        else if (!push && pop) level_d = level_q - LVL_W'(1);
        full_d = (level_d == LVL_W'(FIFO_DEPTH));
        ovf_d  = ovf_q || (cpu_we && full_q);
    end

    // Request latches and result capture.
    always_comb begin
        gpu_pend_d = gpu_rd_req || (gpu_pend_q && (state_d != S_GRD1));
        gpu_addr_d = gpu_rd_req ? gpu_addr : gpu_addr_q;
        cpu_pend_d = accept || (cpu_pend_q && (state_d != S_CRD1));
        cpu_addr_d = accept ? cpu_rd_addr : cpu_addr_q;
        // Busy stays high through the valid cycle, then drops.
        busy_d     = accept || (busy_q && !cvalid_q);
        gvalid_d   = (state_q == S_GRD2);
        cvalid_d   = (state_q == S_CRD2);
        gdata_d    = gvalid_d ? sram_dq_in : gdata_q;
        cdata_d    = cvalid_d ? sram_dq_in : cdata_q;
    end

    // SRAM pins are decoded from the next state so they are registered yet
    // line up with the state they belong to.
    always_comb begin
        rd_state = (state_d == S_GRD1) || (state_d == S_GRD2) ||
                   (state_d == S_CRD1) || (state_d == S_CRD2);
        cs_n_d   = (state_d == S_IDLE);
        oe_n_d   = !rd_state;
        we_n_d   = (state_d != S_WR2);
        dq_oe_d  = (state_d == S_WR1) || (state_d == S_WR2) || (state_d == S_WR3);
        saddr_d  = saddr_q;
        dq_out_d = dq_out_q;
        case (state_d)
            S_GRD1: saddr_d = map_addr(gpu_addr_q);
            S_CRD1: saddr_d = map_addr(cpu_addr_q);
            S_WR1: begin
                saddr_d  = map_addr(head[ENT_W-1:DATA_WIDTH]);
                dq_out_d = head[DATA_WIDTH-1:0];
            end
            default: ;
        endcase
    end

    // FIFO storage carries no reset; pointers and level define its contents.
    always_ff @(posedge clk100) begin
        if (push) fifo_mem[wr_ptr_q] <= {cpu_addr, cpu_data};
    end

    always_ff @(posedge clk100) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
            gpu_pend_q <= 1'b0;
            gpu_addr_q <= '0;
            cpu_pend_q <= 1'b0;
            cpu_addr_q <= '0;
            busy_q     <= 1'b0;
            gdata_q    <= '0;
            cdata_q    <= '0;
            gvalid_q   <= 1'b0;
            cvalid_q   <= 1'b0;
            saddr_q    <= '0;
            dq_out_q   <= '0;
            dq_oe_q    <= 1'b0;
            cs_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
            gpu_pend_q <= gpu_pend_d;
            gpu_addr_q <= gpu_addr_d;
            cpu_pend_q <= cpu_pend_d;
            cpu_addr_q <= cpu_addr_d;
            busy_q     <= busy_d;
            gdata_q    <= gdata_d;
            cdata_q    <= cdata_d;
            gvalid_q   <= gvalid_d;
            cvalid_q   <= cvalid_d;
            saddr_q    <= saddr_d;
            dq_out_q   <= dq_out_d;
            dq_oe_q    <= dq_oe_d;
            cs_n_q     <= cs_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
        end
    end

    assign cpu_rd_data    = cdata_q;
    assign cpu_rd_valid   = cvalid_q;
    assign cpu_rd_busy    = busy_q;
    assign fifo_level     = level_q;
    assign fifo_full      = full_q;
    assign fifo_overflow  = ovf_q;
    assign gpu_data       = gdata_q;
    assign gpu_data_valid = gvalid_q;
    assign sram_addr      = saddr_q;
    assign sram_dq_out    = dq_out_q;
    assign sram_dq_oe     = dq_oe_q;
    assign sram_cs_n      = cs_n_q;
    assign sram_oe_n      = oe_n_q;
    assign sram_we_n      = we_n_q;

endmodule

// File: tb/tb_sram_fb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_fb_arbiter
//   Directed bench for sram_fb_arbiter with a behavioural async SRAM model.
//   A second instance with BASE_ADDR=0x7FFFF exercises address wrap.
// ---------------------------------------------------------------------------
module tb_sram_fb_arbiter;

    logic        clk100 = 1'b0;
    logic        reset;
    logic        cpu_we, cpu_rd_req, gpu_active, gpu_rd_req;
    logic [16:0] cpu_addr, cpu_rd_addr, gpu_addr;
    logic [7:0]  cpu_data, sram_dq_in;
    logic [7:0]  cpu_rd_data, gpu_data, sram_dq_out;
    logic        cpu_rd_valid, cpu_rd_busy, fifo_full, fifo_overflow, gpu_data_valid;
    logic [9:0]  fifo_level;
    logic [18:0] sram_addr;
    logic        sram_dq_oe, sram_cs_n, sram_oe_n, sram_we_n;

    // Wrap-instance signals
    logic        w_gpu_rd_req;
    logic [16:0] w_gpu_addr;
    logic [7:0]  w_cpu_rd_data, w_gpu_data, w_sram_dq_out;
    logic        w_cpu_rd_valid, w_cpu_rd_busy, w_fifo_full, w_fifo_overflow, w_gpu_data_valid;
    logic [9:0]  w_fifo_level;
    logic [18:0] w_sram_addr;
    logic        w_sram_dq_oe, w_sram_cs_n, w_sram_oe_n, w_sram_we_n;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk100 = ~clk100;

    sram_fb_arbiter #(.ADDR_WIDTH(17), .DATA_WIDTH(8), .SRAM_ADDR_WIDTH(19),
                      .FIFO_DEPTH(512), .BASE_ADDR(0)) u_dut (
        .clk100(clk100), .reset(reset),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr),
        .cpu_rd_data(cpu_rd_data), .cpu_rd_valid(cpu_rd_valid), .cpu_rd_busy(cpu_rd_busy),
        .fifo_level(fifo_level), .fifo_full(fifo_full), .fifo_overflow(fifo_overflow),
        .gpu_active(gpu_active), .gpu_rd_req(gpu_rd_req), .gpu_addr(gpu_addr),
        .gpu_data(gpu_data), .gpu_data_valid(gpu_data_valid),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
        .sram_dq_oe(sram_dq_oe), .sram_cs_n(sram_cs_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n)
    );

    sram_fb_arbiter #(.ADDR_WIDTH(17), .DATA_WIDTH(8), .SRAM_ADDR_WIDTH(19),
                      .FIFO_DEPTH(512), .BASE_ADDR(32'h7FFFF)) u_dut_wrap (
        .clk100(clk100), .reset(reset),
        .cpu_we(1'b0), .cpu_addr(17'h0), .cpu_data(8'h00),
        .cpu_rd_req(1'b0), .cpu_rd_addr(17'h0),
        .cpu_rd_data(w_cpu_rd_data), .cpu_rd_valid(w_cpu_rd_valid), .cpu_rd_busy(w_cpu_rd_busy),
        .fifo_level(w_fifo_level), .fifo_full(w_fifo_full), .fifo_overflow(w_fifo_overflow),
        .gpu_active(1'b0), .gpu_rd_req(w_gpu_rd_req), .gpu_addr(w_gpu_addr),
        .gpu_data(w_gpu_data), .gpu_data_valid(w_gpu_data_valid),
        .sram_addr(w_sram_addr), .sram_dq_out(w_sram_dq_out), .sram_dq_in(8'h00),
        .sram_dq_oe(w_sram_dq_oe), .sram_cs_n(w_sram_cs_n), .sram_oe_n(w_sram_oe_n),
        .sram_we_n(w_sram_we_n)
    );

    // Async SRAM model; single writer process, preload through a backdoor.
    bit   [7:0]  sram_mem [0:131071];
    logic        bd_we = 1'b0;
    logic [16:0] bd_addr;
    logic [7:0]  bd_data;
    int          wr_count = 0, dq_oe_cycles = 0, turn_viol = 0;
    logic [18:0] wr_log [$];

    assign sram_dq_in = (!sram_cs_n && !sram_oe_n) ? sram_mem[sram_addr[16:0]] : 8'h00;

    always @(posedge clk100) begin
        if (bd_we) sram_mem[bd_addr] = bd_data;
        if (!sram_cs_n && !sram_we_n) begin
            sram_mem[sram_addr[16:0]] = sram_dq_out;
            wr_count++;
            wr_log.push_back(sram_addr);
        end
        if (sram_dq_oe && !sram_oe_n) turn_viol++;
        if (sram_dq_oe) dq_oe_cycles++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    task automatic preload(input logic [16:0] a, input logic [7:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        tick();
        bd_we   = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int wr0, oe0, lat, c, first_rd, last_wr, nonbusy, nvalid, base;

        reset = 1'b1; cpu_we = 1'b0; cpu_rd_req = 1'b0; gpu_active = 1'b0; gpu_rd_req = 1'b0;
        cpu_addr = '0; cpu_data = '0; cpu_rd_addr = '0; gpu_addr = '0;
        w_gpu_rd_req = 1'b0; w_gpu_addr = '0;
        repeat (3) tick();
        preload(17'h00010, 8'hA5);
        preload(17'h00020, 8'h3C);
        reset = 1'b0;
        tick();

        // Reset state
        check_eq("rst_ctrl_n", 32'({sram_cs_n, sram_oe_n, sram_we_n}), 32'h7);
        check_eq("rst_dq_oe", 32'(sram_dq_oe), 0);
        check_eq("rst_addr", 32'(sram_addr), 0);
        check_eq("rst_dq_out", 32'(sram_dq_out), 0);
        check_eq("rst_fifo", 32'({fifo_level, fifo_full, fifo_overflow}), 0);
        check_eq("rst_outs", 32'({cpu_rd_valid, cpu_rd_busy, gpu_data_valid, gpu_data, cpu_rd_data}), 0);

        // 1: GPU read latency N+3
        gpu_addr = 17'h00010; gpu_rd_req = 1'b1;
        tick();                      // edge N
        gpu_rd_req = 1'b0;
        check_eq("t1_n0_cs_n", 32'(sram_cs_n), 1);
        tick();                      // N+1 : GRD1
        check_eq("t1_n1_ctrl", 32'({sram_cs_n, sram_oe_n, gpu_data_valid}), 0);
        check_eq("t1_n1_addr", 32'(sram_addr), 32'h10);
        tick();                      // N+2 : GRD2
        check_eq("t1_n2_ctrl", 32'({sram_cs_n, sram_oe_n, gpu_data_valid}), 0);
        tick();                      // N+3 : valid
        check_eq("t1_n3_valid", 32'(gpu_data_valid), 1);
        check_eq("t1_n3_data", 32'(gpu_data), 32'hA5);
        check_eq("t1_n3_cs_n", 32'(sram_cs_n), 1);
        tick();
        check_eq("t1_n4_valid", 32'(gpu_data_valid), 0);

        // 2: queued writes held off by gpu_active, then drained in order
        gpu_active = 1'b1;
        wr0 = wr_count; oe0 = dq_oe_cycles; base = wr_log.size();
        for (int i = 0; i < 4; i++) begin
            cpu_we = 1'b1; cpu_addr = 17'(i); cpu_data = 8'((i + 1) * 'h11);
            tick();
        end
        cpu_we = 1'b0;
        repeat (2) tick();
        check_eq("t2_level4", 32'(fifo_level), 4);
        check_eq("t2_no_wr", 32'(wr_count - wr0), 0);
        check_eq("t2_cs_idle", 32'(sram_cs_n), 1);
        gpu_active = 1'b0;
        repeat (20) tick();
        check_eq("t2_level0", 32'(fifo_level), 0);
        check_eq("t2_wr_cnt", 32'(wr_count - wr0), 4);
        check_eq("t2_oe_cycles", 32'(dq_oe_cycles - oe0), 12);
        for (int i = 0; i < 4; i++) begin
            check_eq("t2_order", 32'(wr_log[base + i]), 32'(i));
            check_eq("t2_mem", 32'(sram_mem[i]), 32'((i + 1) * 'h11));
        end

        // 3: fill to 512, overflow on 513th, sticky after drain
        gpu_active = 1'b1;
        wr0 = wr_count;
        for (int i = 0; i < 512; i++) begin
            cpu_we = 1'b1; cpu_addr = 17'(32'h1000 + i); cpu_data = 8'(i);
            tick();
        end
        check_eq("t3_level512", 32'(fifo_level), 512);
        check_eq("t3_full", 32'(fifo_full), 1);
        check_eq("t3_no_ovf_yet", 32'(fifo_overflow), 0);
        cpu_addr = 17'h01200; cpu_data = 8'hEE;
        tick();
        cpu_we = 1'b0;
        check_eq("t3_ovf", 32'(fifo_overflow), 1);
        check_eq("t3_level_hold", 32'(fifo_level), 512);
        check_eq("t3_full_hold", 32'(fifo_full), 1);
        gpu_active = 1'b0;
        for (int i = 0; i < 3000 && fifo_level != 0; i++) tick();
        repeat (4) tick();
        check_eq("t3_drained", 32'(fifo_level), 0);
        check_eq("t3_full_clr", 32'(fifo_full), 0);
        check_eq("t3_ovf_sticky", 32'(fifo_overflow), 1);
        check_eq("t3_wr_cnt", 32'(wr_count - wr0), 512);
        check_eq("t3_mem_first", 32'(sram_mem[17'h01080]), 32'h80);
        check_eq("t3_mem_last", 32'(sram_mem[17'h011FF]), 32'hFF);
        check_eq("t3_mem_dropped", 32'(sram_mem[17'h01200]), 0);

        // 4: coherent read-after-write, busy window, request while busy ignored
        cpu_we = 1'b1; cpu_addr = 17'd7; cpu_data = 8'h5A;
        tick();
        cpu_we = 1'b0; cpu_rd_req = 1'b1; cpu_rd_addr = 17'd7;
        tick();
        check_eq("t4_busy_acc", 32'(cpu_rd_busy), 1);
        cpu_rd_req = 1'b1; cpu_rd_addr = 17'd3;     // ignored: busy
        tick();
        cpu_rd_req = 1'b0;
        first_rd = -1; last_wr = -1; nonbusy = 0; c = 0;
        while (!cpu_rd_valid && c < 30) begin
            if (sram_dq_oe) last_wr = c;
            if (!sram_oe_n && first_rd < 0) first_rd = c;
            if (!cpu_rd_busy) nonbusy++;
            tick();
            c++;
        end
        check_eq("t4_valid", 32'(cpu_rd_valid), 1);
        check_eq("t4_busy_at_valid", 32'(cpu_rd_busy), 1);
        check_eq("t4_data", 32'(cpu_rd_data), 32'h5A);
        check_eq("t4_busy_gap", 32'(nonbusy), 0);
        check_eq("t4_rd_after_wr", 32'(first_rd > last_wr && last_wr >= 0), 1);
        tick();
        check_eq("t4_done", 32'({cpu_rd_busy, cpu_rd_valid}), 0);
        nvalid = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cpu_rd_valid) nvalid++;
        end
        check_eq("t4_2nd_ignored", 32'(nvalid), 0);
        check_eq("t4_data_hold", 32'(cpu_rd_data), 32'h5A);

        // 5: GPU request during WR2 chained right after WR3
        cpu_we = 1'b1; cpu_addr = 17'd9; cpu_data = 8'h99;
        tick();
        cpu_we = 1'b0;
        for (int i = 0; i < 10 && sram_we_n; i++) tick();
        check_eq("t5_in_wr2", 32'(sram_we_n), 0);
        gpu_addr = 17'h00020; gpu_rd_req = 1'b1;
        tick();
        gpu_rd_req = 1'b0;
        lat = 0;
        check_eq("t5_wr3", 32'({sram_dq_oe, sram_we_n, sram_cs_n}), 32'h6);
        tick(); lat++;
        check_eq("t5_grd1_direct", 32'({sram_oe_n, sram_cs_n, sram_dq_oe}), 0);
        check_eq("t5_grd1_addr", 32'(sram_addr), 32'h20);
        while (!gpu_data_valid && lat < 10) begin
            tick(); lat++;
        end
        check_eq("t5_lat_le5", 32'(gpu_data_valid && lat <= 5), 1);
        check_eq("t5_data", 32'(gpu_data), 32'h3C);
        check_eq("t5_wr_mem", 32'(sram_mem[9]), 32'h99);

        // 5b: BASE_ADDR wrap on the second instance
        w_gpu_addr = 17'd2; w_gpu_rd_req = 1'b1;
        tick();
        w_gpu_rd_req = 1'b0;
        tick();
        check_eq("t5_wrap_cs", 32'(w_sram_cs_n), 0);
        check_eq("t5_wrap_addr", 32'(w_sram_addr), 32'h00001);

        // 6: reset during WR2
        repeat (4) tick();
        cpu_we = 1'b1; cpu_addr = 17'h30; cpu_data = 8'h77;
        cpu_rd_req = 1'b1; cpu_rd_addr = 17'h30;
        tick();
        cpu_rd_req = 1'b0; cpu_addr = 17'h31; cpu_data = 8'h78;
        tick();
        cpu_addr = 17'h32; cpu_data = 8'h79;
        tick();
        cpu_we = 1'b0;
        check_eq("t6_pre_wr2", 32'(sram_we_n), 0);
        check_eq("t6_pre_busy", 32'(cpu_rd_busy), 1);
        check_eq("t6_pre_level", 32'(fifo_level), 2);
        reset = 1'b1;
        tick();
        check_eq("t6_ctrl_off", 32'({sram_we_n, sram_cs_n, sram_oe_n, sram_dq_oe}), 32'hE);
        check_eq("t6_level", 32'(fifo_level), 0);
        check_eq("t6_busy", 32'(cpu_rd_busy), 0);
        check_eq("t6_ovf_clr", 32'(fifo_overflow), 0);
        reset = 1'b0;
        nvalid = 0; c = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (cpu_rd_valid) nvalid++;
            if (!sram_cs_n) c++;
        end
        check_eq("t6_no_resume", 32'(c), 0);
        check_eq("t6_no_valid", 32'(nvalid), 0);

        check_eq("turnaround", 32'(turn_viol), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
